// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared types and constants for the register-file write-port
// controller.
//   state_t      : controller phase, CLEAR (post-reset zero-fill) or RUN
//   DEF_ADDR_W   : default register address width
//   DEF_DATA_W   : default write data width
//   ZERO_REG     : index of the hardwired-zero register; writes to it are dropped
package rf_ctrl_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;
   localparam int ZERO_REG   = 0;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/rf_wb_hold.sv
// rf_wb_hold: one-entry holding register for a writeback request that lost
// the write port to a forced MDU grant.
//   clk, rst         : clock, synchronous active-high reset
//   load             : capture load_wa/load_wd and mark the entry full
//   drain            : entry was issued this cycle; mark it empty
//   load_wa, load_wd : request captured on load
//   full             : entry holds a pending request
//   wa, wd           : pending request, valid while full
module rf_wb_hold
   import rf_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              drain,
   input  logic [ADDR_W-1:0] load_wa,
   input  logic [DATA_W-1:0] load_wd,
   output logic              full,
   output logic [ADDR_W-1:0] wa,
   output logic [DATA_W-1:0] wd
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst)
         full <= 1'b0;
      else if (load)
         full <= 1'b1;
      else if (drain)
         full <= 1'b0;
   end

   // NOTE: the payload is deliberately not reset; it is only looked at while
   // full is set, and full itself is reset.
   always_ff @(posedge clk) begin
      if (load) begin
         wa <= load_wa;
         wd <= load_wd;
      end
   end

endmodule

// File: rtl/rf_write_ctrl.sv
// rf_write_ctrl: write-port controller for the register file. Zero-fills all
// NREGS registers after reset, then arbitrates the single write port between
// pipeline writeback (wb_*) and the multi-cycle MDU (mdu_*), forcing the MDU
// through after STARVE_LIM wait cycles and parking the displaced writeback in
// a one-entry hold register.
//   clk, rst                 : clock, synchronous active-high reset
//   wb_we, wb_wa, wb_wd      : pipeline writeback request (no backpressure)
//   mdu_valid, mdu_wa, mdu_wd: MDU result request
//   mdu_ready                : combinational MDU accept
//   rf_we, rf_wa, rf_wd      : registered register-file write port
//   stall_req                : registered; pipeline must hold wb_we=0 while set
//   init_done                : registered; zero-fill complete
module rf_write_ctrl
   import rf_ctrl_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int NREGS      = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   input  logic              mdu_valid,
   input  logic [ADDR_W-1:0] mdu_wa,
   input  logic [DATA_W-1:0] mdu_wd,
   output logic              mdu_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic              stall_req,
   output logic              init_done
);

   localparam int                  STARVE_W   = $clog2(STARVE_LIM + 1);
   localparam logic [ADDR_W-1:0]   ZERO_A     = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W-1:0]   LAST_IDX   = ADDR_W'(NREGS - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   idx;
   logic [STARVE_W-1:0] starve;

   logic                hold_full;
   logic [ADDR_W-1:0]   hold_wa;
   logic [DATA_W-1:0]   hold_wd;

   logic wb_eff, mdu_eff, forced, mdu_xfer, hold_load, hold_drain, last_clear;

   rf_wb_hold #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load    (hold_load),
      .drain   (hold_drain),
      .load_wa (wb_wa),
      .load_wd (wb_wd),
      .full    (hold_full),
      .wa      (hold_wa),
      .wd      (hold_wd)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= CLEAR;
      else
         state <= state_nxt;
   end

   // Next state: leave CLEAR once the last sweep address has been issued
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch forms.
      state_nxt = state;
      if (state == CLEAR && last_clear)
         state_nxt = RUN;
   end

   // Arbitration decode
   always_comb begin
      wb_eff     = wb_we && (wb_wa != ZERO_A);
      mdu_eff    = (mdu_wa != ZERO_A);
      forced     = (starve == STARVE_MAX);
      last_clear = (idx == LAST_IDX);
      // A live writeback blocks the MDU unless the MDU has waited long enough.
      mdu_ready  = (state == RUN) && !hold_full && (!wb_eff || forced);
      mdu_xfer   = mdu_valid && mdu_ready;
      // mdu_xfer with a live writeback only happens on a forced grant.
      hold_load  = mdu_xfer && forced && wb_eff;
      hold_drain = (state == RUN) && hold_full;
   end

   // Registered write port, sweep index, starve counter and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         starve    <= '0;
         rf_we     <= 1'b0;
         rf_wa     <= '0;
         rf_wd     <= '0;
         stall_req <= 1'b1;
         init_done <= 1'b0;
      end else if (state == CLEAR) begin
         rf_we     <= 1'b1;
         rf_wa     <= idx;
         rf_wd     <= '0;
         idx       <= idx + 1'b1;
         starve    <= '0;
         stall_req <= 1'b1;
         init_done <= 1'b0;
      end else begin
         init_done <= 1'b1;
         stall_req <= hold_load;

         if (mdu_valid && !mdu_ready)
            starve <= forced ? starve : starve + 1'b1;
         else
            starve <= '0;

         // Idle and $0 cycles drop rf_we but keep address/data unchanged.
         rf_we <= 1'b0;
         if (hold_full) begin
            rf_we <= 1'b1;
            rf_wa <= hold_wa;
            rf_wd <= hold_wd;
         end else if (mdu_xfer) begin
            if (mdu_eff) begin
               rf_we <= 1'b1;
               rf_wa <= mdu_wa;
               rf_wd <= mdu_wd;
            end
         end else if (wb_eff) begin
            rf_we <= 1'b1;
            rf_wa <= wb_wa;
            rf_wd <= wb_wd;
         end
      end
   end

endmodule

// File: tb/tb_rf_write_ctrl.sv
// tb_rf_write_ctrl: self-checking bench for rf_write_ctrl. A queue-based
// behavioural model predicts the write port every cycle; directed sequences
// add literal expectations for zero-fill, contention, $0 filtering and reset.
module tb_rf_write_ctrl;

   localparam int STARVE_LIM = 4;

   typedef struct packed {
      logic [4:0]  wa;
      logic [31:0] wd;
   } req_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wd;
   logic        mdu_valid;
   logic [4:0]  mdu_wa;
   logic [31:0] mdu_wd;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        stall_req;
   logic        init_done;

   int errors = 0;
   int checks = 0;

   // Register file as seen through the DUT write port (committed at negedge)
   logic [31:0] obs_regs [32];

   // Behavioural model
   bit          m_known = 0;
   bit          m_run   = 0;
   int          m_sweep = 0;
   int          m_wait  = 0;
   req_t        held[$];
   logic        e_we, e_stall, e_init;
   logic [4:0]  e_wa;
   logic [31:0] e_wd;

   rf_write_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .wb_we     (wb_we),
      .wb_wa     (wb_wa),
      .wb_wd     (wb_wd),
      .mdu_valid (mdu_valid),
      .mdu_wa    (mdu_wa),
      .mdu_wd    (mdu_wd),
      .mdu_ready (mdu_ready),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd),
      .stall_req (stall_req),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_ready(input bit wb_live);
      return m_run && (held.size() == 0) && (!wb_live || m_wait == STARVE_LIM);
   endfunction

   // Model: what the write port must show after each posedge
   always @(posedge clk) begin
      bit   wb_live, rdy;
      req_t r;
      if (rst) begin
         m_known = 1;
         m_run   = 0;
         m_sweep = 0;
         m_wait  = 0;
         held.delete();
         e_we = 0; e_wa = 0; e_wd = 0; e_stall = 1; e_init = 0;
      end else if (m_known) begin
         if (!m_run) begin
            e_we = 1; e_wa = 5'(m_sweep); e_wd = 0; e_stall = 1; e_init = 0;
            m_sweep++;
            if (m_sweep == 32) m_run = 1;
         end else begin
            wb_live = wb_we && (wb_wa != 0);
            rdy     = exp_ready(wb_live);
            e_init  = 1;
            e_stall = 0;
            e_we    = 0;
            if (held.size() > 0) begin
               r = held.pop_front();
               e_we = 1; e_wa = r.wa; e_wd = r.wd;
            end else if (mdu_valid && rdy) begin
               if (mdu_wa != 0) begin
                  e_we = 1; e_wa = mdu_wa; e_wd = mdu_wd;
               end
               if (wb_live) begin
                  held.push_back('{wa: wb_wa, wd: wb_wd});
                  e_stall = 1;
               end
            end else if (wb_live) begin
               e_we = 1; e_wa = wb_wa; e_wd = wb_wd;
            end
            if (mdu_valid && !rdy)
               m_wait = (m_wait < STARVE_LIM) ? m_wait + 1 : STARVE_LIM;
            else
               m_wait = 0;
         end
      end
   end

   // Compare every cycle at negedge, then commit to the observed register file
   always @(negedge clk) begin
      if (m_known) begin
         check("rf_we", rf_we, e_we);
         check("rf_wa", rf_wa, e_wa);
         check("rf_wd", rf_wd, e_wd);
         check("stall_req", stall_req, e_stall);
         check("init_done", init_done, e_init);
         if (!rst)
            check("mdu_ready", mdu_ready, exp_ready(wb_we && (wb_wa != 0)));
      end
      if (rf_we === 1'b1)
         obs_regs[rf_wa] = rf_wd;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_we = 0; wb_wa = 0; wb_wd = 0;
      mdu_valid = 0; mdu_wa = 0; mdu_wd = 0;
   endtask

   // Full zero-fill after reset release, with literal expectations
   task automatic sweep();
      for (int k = 0; k < 32; k++) begin
         step();
         check("sweep_we", rf_we, 1);
         check("sweep_wa", rf_wa, k);
         check("sweep_wd", rf_wd, 0);
         check("sweep_init", init_done, 0);
      end
      check("ready_after_sweep", mdu_ready, 1);
      step();
      check("init_done_33", init_done, 1);
      check("stall_33", stall_req, 0);
      check("idle_we_33", rf_we, 0);
   endtask

   // Writeback every cycle plus a pending MDU until the MDU is let through
   task automatic contend(input int base, output int zeros, output bit got);
      zeros = 0;
      got   = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         wb_we = 1; wb_wa = 5'(base + c); wb_wd = 32'h100 + c;
         mdu_valid = 1; mdu_wa = 5'd3; mdu_wd = 32'h55;
         #1;
         if (mdu_ready) got = 1;
         else zeros++;
         step();
      end
      check("mdu_forced_in_time", 32'(got), 1);
   endtask

   initial begin : main
      int  zeros;
      bit  got;
      for (int i = 0; i < 32; i++) obs_regs[i] = 32'hFFFF_FFFF;
      rst = 1;
      idle_inputs();
      step();
      step();
      check("reset_we", rf_we, 0);
      check("reset_stall", stall_req, 1);
      check("reset_init", init_done, 0);
      rst = 0;

      // Zero-fill
      sweep();
      settle();
      for (int i = 0; i < 32; i++) check("zero_fill_reg", obs_regs[i], 0);

      // No contention
      wb_we = 1; wb_wa = 5'd8; wb_wd = 32'hDEAD_BEEF;
      step();
      wb_we = 0;
      check("wb8_we", rf_we, 1);
      check("wb8_wa", rf_wa, 8);
      check("wb8_wd", rf_wd, 32'hDEAD_BEEF);
      settle();
      check("reg8", obs_regs[8], 32'hDEAD_BEEF);

      // Contention: MDU waits 4 cycles, then forced; wb at 14 is held
      contend(10, zeros, got);
      idle_inputs();
      check("starve_wait_cycles", zeros, 4);
      check("forced_we", rf_we, 1);
      check("forced_wa", rf_wa, 3);
      check("forced_wd", rf_wd, 32'h55);
      check("forced_stall", stall_req, 1);
      step();
      check("held_we", rf_we, 1);
      check("held_wa", rf_wa, 14);
      check("held_wd", rf_wd, 32'h104);
      check("held_stall", stall_req, 0);
      step();
      check("post_hold_we", rf_we, 0);
      settle();
      check("reg3", obs_regs[3], 32'h55);
      check("reg13", obs_regs[13], 32'h103);
      check("reg14", obs_regs[14], 32'h104);

      // $0 filter: both requests accepted, nothing issued
      wb_we = 1; wb_wa = 5'd0; wb_wd = 32'h1;
      mdu_valid = 1; mdu_wa = 5'd0; mdu_wd = 32'h77;
      #1;
      check("zero_ready", mdu_ready, 1);
      step();
      idle_inputs();
      check("zero_we", rf_we, 0);
      check("zero_wa_hold", rf_wa, 14);
      check("zero_wd_hold", rf_wd, 32'h104);
      settle();
      check("reg0", obs_regs[0], 0);

      // Uncontended MDU write
      mdu_valid = 1; mdu_wa = 5'd20; mdu_wd = 32'h0000_ABCD;
      step();
      idle_inputs();
      check("mdu20_wa", rf_wa, 20);
      check("mdu20_wd", rf_wd, 32'h0000_ABCD);

      // Reset at sweep index 17
      rst = 1;
      step();
      rst = 0;
      for (int k = 0; k < 17; k++) step();
      check("pre17_wa", rf_wa, 16);
      rst = 1;
      step();
      check("mid_sweep_rst_we", rf_we, 0);
      check("mid_sweep_rst_wa", rf_wa, 0);
      check("mid_sweep_rst_stall", stall_req, 1);
      rst = 0;
      sweep();

      // Reset with the hold register full: held wb (address 25) is discarded
      contend(21, zeros, got);
      idle_inputs();
      check("hold_full_stall", stall_req, 1);
      rst = 1;
      step();
      rst = 0;
      check("hold_rst_we", rf_we, 0);
      sweep();
      step();
      check("no_stale_we", rf_we, 0);
      settle();
      check("reg25_cleared", obs_regs[25], 0);

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
